// File: rtl/mult_acc_seq.sv
// mult_acc_seq
// Streams LEN unsigned 32x32 operand pairs into an external registered
// multiplier (one-cycle latency, CE-gated, synchronous SCLR) and sums the
// returned 64-bit products into an ACC_W-bit accumulator. The dot-product
// is presented on a valid/ready output together with a sticky overflow flag.
//
// Ports:
//   CLK, RSTN            clock (rising edge), asynchronous active-low reset
//   START, LEN           begin a vector of LEN pairs (sampled only when idle)
//   IN_VALID, IN_READY   operand-pair handshake; IN_A, IN_B operands
//   MUL_A, MUL_B         operands to the multiplier (combinational pass-through)
//   MUL_CE, MUL_SCLR     multiplier clock enable / synchronous clear
//   MUL_P                registered product returned by the multiplier
//   OUT_VALID, OUT_READY result handshake; OUT_SUM result, OUT_OVF sticky carry
//   BUSY                 high whenever a vector is in progress or unread
module mult_acc_seq #(
  parameter int ACC_W = 72,
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_A,
  input  logic [31:0]      IN_B,
  output logic [31:0]      MUL_A,
  output logic [31:0]      MUL_B,
  output logic             MUL_CE,
  output logic             MUL_SCLR,
  input  logic [63:0]      MUL_P,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] OUT_SUM,
  output logic             OUT_OVF,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [LEN_W-1:0] count_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             iss_d_r;   // a product was issued last cycle and is now on MUL_P
  logic             beat_s;
  logic             start_s;
  logic [ACC_W:0]   sum_s;     // one extra bit to capture the carry out

  assign beat_s  = IN_VALID & (state_r == RUN);
  assign start_s = START & (state_r == IDLE);
  assign sum_s   = {1'b0, acc_r} + {{(ACC_W + 1 - 64){1'b0}}, MUL_P};

  assign MUL_A     = IN_A;
  assign MUL_B     = IN_B;
  assign MUL_CE    = beat_s;
  // Held low while in reset so the multiplier is not cleared by a stray START.
  assign MUL_SCLR  = start_s & RSTN;
  assign IN_READY  = (state_r == RUN);
  assign OUT_VALID = (state_r == DONE);
  assign BUSY      = (state_r != IDLE);
  assign OUT_SUM   = acc_r;
  assign OUT_OVF   = ovf_r;

  // Next-state decode for the vector sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = (LEN == {LEN_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (beat_s && (count_r == LEN_W'(1))) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        // The final product is being accumulated this cycle.
        state_nxt_s = DONE;
      end
      DONE: begin
        if (OUT_READY) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Remaining-pair counter and issue flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_r <= {LEN_W{1'b0}};
      iss_d_r <= 1'b0;
    end else begin
      iss_d_r <= beat_s;
      if (start_s) begin
        count_r <= LEN;
      end else if (beat_s) begin
        count_r <= count_r - LEN_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Accumulator and sticky overflow; keyed on iss_d only, so a held MUL_P
  // between beats is never added twice.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (start_s) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (iss_d_r) begin
      acc_r <= sum_s[ACC_W-1:0];
      ovf_r <= ovf_r | sum_s[ACC_W];
    end else begin
      acc_r <= acc_r;
      ovf_r <= ovf_r;
    end
  end

endmodule

// File: tb/tb_mult_acc_seq.sv
// Self-checking bench for mult_acc_seq. Two instances (ACC_W=72 and ACC_W=64)
// share the same stimulus; each drives its own behavioural multiplier. The
// expected dot-product is computed directly as a 128-bit sum of products.
module tb_mult_acc_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_ready;

  logic        in_ready_w, in_ready_n;
  logic [31:0] mul_a_w, mul_b_w, mul_a_n, mul_b_n;
  logic        ce_w, ce_n, sclr_w, sclr_n;
  logic [63:0] p_w, p_n;
  logic        out_valid_w, out_valid_n;
  logic [71:0] sum_w;
  logic [63:0] sum_n;
  logic        ovf_w, ovf_n, busy_w, busy_n;

  int errors = 0;
  int checks = 0;
  int ce_cnt = 0;
  logic [31:0] va [16];
  logic [31:0] vb [16];

  mult_acc_seq #(.ACC_W(72), .LEN_W(16)) dut_w (
    .CLK(clk), .RSTN(rstn), .START(start), .LEN(len),
    .IN_VALID(in_valid), .IN_READY(in_ready_w), .IN_A(in_a), .IN_B(in_b),
    .MUL_A(mul_a_w), .MUL_B(mul_b_w), .MUL_CE(ce_w), .MUL_SCLR(sclr_w),
    .MUL_P(p_w), .OUT_VALID(out_valid_w), .OUT_READY(out_ready),
    .OUT_SUM(sum_w), .OUT_OVF(ovf_w), .BUSY(busy_w)
  );

  mult_acc_seq #(.ACC_W(64), .LEN_W(16)) dut_n (
    .CLK(clk), .RSTN(rstn), .START(start), .LEN(len),
    .IN_VALID(in_valid), .IN_READY(in_ready_n), .IN_A(in_a), .IN_B(in_b),
    .MUL_A(mul_a_n), .MUL_B(mul_b_n), .MUL_CE(ce_n), .MUL_SCLR(sclr_n),
    .MUL_P(p_n), .OUT_VALID(out_valid_n), .OUT_READY(out_ready),
    .OUT_SUM(sum_n), .OUT_OVF(ovf_n), .BUSY(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural registered multipliers (SCLR has priority over CE).
  always @(posedge clk) begin
    if (sclr_w) p_w <= 64'd0;
    else if (ce_w) p_w <= {32'd0, mul_a_w} * {32'd0, mul_b_w};
    if (sclr_n) p_n <= 64'd0;
    else if (ce_n) p_n <= {32'd0, mul_a_n} * {32'd0, mul_b_n};
  end

  // Count issued beats for the wide instance.
  always @(posedge clk) begin
    if (ce_w === 1'b1) ce_cnt = ce_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " valid"}, {out_valid_w, out_valid_n}, 128'd0);
    check_eq({tag, " busy"}, {busy_w, busy_n}, 128'd0);
    check_eq({tag, " in_ready"}, {in_ready_w, in_ready_n}, 128'd0);
  endtask

  // Runs one vector of len pairs from va/vb, starting at a negedge.
  // gap_mode: 0 back-to-back, 1 two idle cycles between beats, 2 random gaps.
  task automatic run_vector(input int len_i, input int gap_mode, input int hold);
    logic [127:0] total;
    int ce_start;
    int gaps;
    total = 128'd0;
    for (int i = 0; i < len_i; i++) total = total + ({96'd0, va[i]} * {96'd0, vb[i]});

    start = 1'b1;
    len = 16'(len_i);
    #1;
    check_eq("sclr pulse", {sclr_w, sclr_n}, 128'd3);
    ce_start = ce_cnt;
    @(negedge clk);
    start = 1'b0;
    if (len_i != 0) begin
      check_eq("run in_ready", {in_ready_w, in_ready_n, busy_w, busy_n}, 128'hF);
      for (int i = 0; i < len_i; i++) begin
        gaps = (gap_mode == 0 || i == 0) ? 0 : (gap_mode == 1 ? 2 : int'($urandom_range(0, 2)));
        for (int g = 0; g < gaps; g++) begin
          in_valid = 1'b0;
          in_a = $urandom;
          #1;
          check_eq("gap ce", {ce_w, ce_n}, 128'd0);
          @(negedge clk);
        end
        in_valid = 1'b1;
        in_a = va[i];
        in_b = vb[i];
        #1;
        check_eq("beat ce", {ce_w, ce_n}, 128'd3);
        check_eq("mul_a", {mul_a_w, mul_b_n}, {va[i], vb[i]});
        @(negedge clk);
      end
      in_valid = 1'($urandom_range(0, 1));
      #1;
      check_eq("drain", {in_ready_w, ce_w, out_valid_w, ce_n, out_valid_n}, 128'd0);
      @(negedge clk);
      in_valid = 1'b0;
    end
    check_eq("done valid", {out_valid_w, out_valid_n}, 128'd3);
    check_eq("sum72", sum_w, {56'd0, total[71:0]});
    check_eq("ovf72", ovf_w, (total[127:72] != 56'd0));
    check_eq("sum64", sum_n, {64'd0, total[63:0]});
    check_eq("ovf64", ovf_n, (total[127:64] != 64'd0));
    check_eq("ce count", ce_cnt - ce_start, len_i);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      #1;
      check_eq("hold sclr", {sclr_w, sclr_n}, 128'd0);
      @(negedge clk);
      check_eq("hold state", {out_valid_w, busy_w, out_valid_n, busy_n}, 128'hF);
      check_eq("hold sum", sum_w, {56'd0, total[71:0]});
    end
    // Handshake with START raised in the same cycle when holding: not captured.
    start = (hold > 0);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check_idle_outputs("after handshake");
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    len = 16'd0;
    in_valid = 1'b0;
    in_a = 32'd0;
    in_b = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset sum", {sum_w, sum_n}, 128'd0);
    check_eq("reset ovf/ce", {ovf_w, ovf_n, ce_w, ce_n}, 128'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Three pairs back-to-back, result held 5 cycles with START pulsing.
    va[0] = 32'd2; vb[0] = 32'd3;
    va[1] = 32'd4; vb[1] = 32'd5;
    va[2] = 32'd6; vb[2] = 32'd7;
    run_vector(3, 0, 5);
    // Same vector with two idle cycles between beats.
    run_vector(3, 1, 0);
    // Empty vector.
    run_vector(0, 0, 1);
    // Largest products: wraps at 64 bits, not at 72.
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;
    run_vector(2, 0, 0);

    // Reset mid-vector after 2 of 4 beats.
    start = 1'b1;
    len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 32'd10 + 32'(i);
      in_b = 32'd20;
      @(negedge clk);
    end
    start = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check_idle_outputs("mid reset");
    check_eq("mid reset sum/ovf", {sum_w, ovf_w, sum_n, ovf_n}, 128'd0);
    check_eq("mid reset ce/sclr", {ce_w, sclr_w, ce_n, sclr_n}, 128'd0);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("post reset");
    va[0] = 32'd3; vb[0] = 32'd3;
    run_vector(1, 0, 0);

    // Randomized vectors with random gaps and output back-pressure.
    for (int v = 0; v < 10; v++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          va[i] = 32'hFFFF_FFFF;
          vb[i] = 32'hFFFF_FFFF;
        end else begin
          va[i] = $urandom;
          vb[i] = $urandom;
        end
      end
      run_vector(n, 2, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
